// File: rtl/symbol_streamer_pkg.sv
// Shared types for the automata symbol streamer: FSM state encoding and symbol width.
package symbol_streamer_pkg;

  localparam int SYM_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    STREAM,
    DRAIN,
    DONE
  } ss_state_t;

endpackage

// File: rtl/symbol_streamer_if.sv
// Wide valid/ready word stream from the input DMA/FIFO into the symbol streamer.
interface symbol_streamer_if #(
  parameter int WORD_W = 64
);
  logic [WORD_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/symbol_word_buf.sv
// One-word staging buffer that serialises a wide word into bytes, byte 0 first.
// With SYMBOL_STREAMER_PERF_EN defined it also exports its valid bit for the perf counters.
module symbol_word_buf
  import symbol_streamer_pkg::*;
#(
  parameter int WORD_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stream,
  input  logic              hold,
  input  logic              last_sym,
  input  logic              more_words,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              consume,
`ifdef SYMBOL_STREAMER_PERF_EN
  output logic              buf_valid,
`endif
  output logic [SYM_W-1:0]  cur_sym
);

  localparam int BYTES  = WORD_W / SYM_W;
  localparam int BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BIDX_W-1:0] LAST_IDX = BIDX_W'(BYTES - 1);

  logic [WORD_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic [BIDX_W-1:0] bidx_q, bidx_d;
  logic              wrap;

  // A refill may land in the same cycle the last byte of the current word is consumed.
  always_comb begin
    consume  = stream && valid_q && !hold;
    wrap     = consume && (bidx_q == LAST_IDX);
    in_ready = stream && (!valid_q || (wrap && more_words));
    cur_sym  = data_q[bidx_q*SYM_W +: SYM_W];
    data_d   = data_q;
    valid_d  = valid_q;
    bidx_d   = bidx_q;
    if (!stream || (consume && last_sym)) begin
      valid_d = 1'b0;
      bidx_d  = '0;
    end else if (in_valid && in_ready) begin
      data_d  = in_data;
      valid_d = 1'b1;
      bidx_d  = '0;
    end else if (wrap) begin
      valid_d = 1'b0;
      bidx_d  = '0;
    end else if (consume) begin
      bidx_d  = bidx_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      bidx_q  <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      bidx_q  <= bidx_d;
    end
  end

`ifdef SYMBOL_STREAMER_PERF_EN
  assign buf_valid = valid_q;
`endif

endmodule

// File: rtl/symbol_streamer.sv
// Feeds the automata bank one symbol per cycle from a wide word stream and sequences its reset.
// Optional SYMBOL_STREAMER_PERF_EN adds stall/starve cycle counters.
module symbol_streamer
  import symbol_streamer_pkg::*;
#(
  parameter int          WORD_W       = 64,
  parameter int          LEN_W        = 32,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [LEN_W-1:0]   num_symbols,
  symbol_streamer_if.slave   in_if,
  input  logic               hold,
  output logic [SYM_W-1:0]   sym_out,
  output logic               sym_run,
  output logic               auto_reset,
  output logic [LEN_W-1:0]   sym_offset,
  output logic               busy,
  output logic               done
`ifdef SYMBOL_STREAMER_PERF_EN
  ,
  output logic [LEN_W-1:0]   perf_stall_cycles,
  output logic [LEN_W-1:0]   perf_starve_cycles
`endif
);

  ss_state_t        state_q, state_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic [31:0]      drain_q, drain_d;
  logic [SYM_W-1:0] sym_out_q, sym_out_d;
  logic             sym_run_q, sym_run_d;
  logic [LEN_W-1:0] sym_offset_q, sym_offset_d;
  logic             auto_reset_q, auto_reset_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             consume;
  logic [SYM_W-1:0] cur_sym;
`ifdef SYMBOL_STREAMER_PERF_EN
  logic             buf_valid;
`endif

  symbol_word_buf #(.WORD_W(WORD_W)) u_buf (
    .clk        (clk),
    .reset      (reset),
    .stream     (state_q == STREAM),
    .hold       (hold),
    .last_sym   (remaining_q == LEN_W'(1)),
    .more_words (remaining_q > LEN_W'(1)),
    .in_data    (in_if.in_data),
    .in_valid   (in_if.in_valid),
    .in_ready   (in_if.in_ready),
    .consume    (consume),
`ifdef SYMBOL_STREAMER_PERF_EN
    .buf_valid  (buf_valid),
`endif
    .cur_sym    (cur_sym)
  );

  // The final symbol is still on sym_out during the first DRAIN cycle, so that entry
  // path drains one extra cycle to give DRAIN_CYCLES quiet cycles before done.
  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    count_d      = count_q;
    drain_d      = drain_q;
    sym_out_d    = sym_out_q;
    sym_run_d    = 1'b0;
    sym_offset_d = sym_offset_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = FLUSH;
          remaining_d  = num_symbols;
          count_d      = '0;
          sym_offset_d = '0;
        end
      end
      FLUSH: begin
        if (remaining_q == '0) begin
          state_d = DRAIN;
          drain_d = (DRAIN_CYCLES == 0) ? 32'd0 : 32'(DRAIN_CYCLES - 1);
        end else begin
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (consume) begin
          sym_run_d    = 1'b1;
          sym_out_d    = cur_sym;
          sym_offset_d = count_q;
          count_d      = count_q + 1'b1;
          remaining_d  = remaining_q - 1'b1;
          if (remaining_q == LEN_W'(1)) begin
            state_d = DRAIN;
            drain_d = 32'(DRAIN_CYCLES);
          end
        end
      end
      DRAIN: begin
        if (drain_q == '0) state_d = DONE;
        else               drain_d = drain_q - 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d       = (state_d != IDLE);
    auto_reset_d = (state_d == IDLE) || (state_d == FLUSH);
    done_d       = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      remaining_q  <= '0;
      count_q      <= '0;
      drain_q      <= '0;
      sym_out_q    <= '0;
      sym_run_q    <= 1'b0;
      sym_offset_q <= '0;
      auto_reset_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      count_q      <= count_d;
      drain_q      <= drain_d;
      sym_out_q    <= sym_out_d;
      sym_run_q    <= sym_run_d;
      sym_offset_q <= sym_offset_d;
      auto_reset_q <= auto_reset_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign sym_out    = sym_out_q;
  assign sym_run    = sym_run_q;
  assign sym_offset = sym_offset_q;
  assign auto_reset = auto_reset_q;
  assign busy       = busy_q;
  assign done       = done_q;

`ifdef SYMBOL_STREAMER_PERF_EN
  logic [LEN_W-1:0] stall_q, stall_d, starve_q, starve_d;

  always_comb begin
    stall_d  = stall_q;
    starve_d = starve_q;
    if (state_q == IDLE && start) begin
      stall_d  = '0;
      starve_d = '0;
    end else if (state_q == STREAM) begin
      if (hold && stall_q != '1)                     stall_d  = stall_q + 1'b1;
      if (!hold && !buf_valid && starve_q != '1)     starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_q  <= '0;
      starve_q <= '0;
    end else begin
      stall_q  <= stall_d;
      starve_q <= starve_d;
    end
  end

  assign perf_stall_cycles  = stall_q;
  assign perf_starve_cycles = starve_q;
`endif

endmodule

// File: tb/tb_symbol_streamer.sv
// Randomised self-checking bench for symbol_streamer; expected symbols come from the word list.
// Builds with or without SYMBOL_STREAMER_PERF_EN.
module tb_symbol_streamer;
  import symbol_streamer_pkg::*;

  localparam int WORD_W = 64;
  localparam int LEN_W  = 32;
  localparam int DRAIN  = 2;
  localparam int BYTES  = WORD_W / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset, start, hold;
  logic [LEN_W-1:0] num_symbols;
  logic [7:0]       sym_out;
  logic             sym_run, auto_reset, busy, done;
  logic [LEN_W-1:0] sym_offset;
`ifdef SYMBOL_STREAMER_PERF_EN
  logic [LEN_W-1:0] perf_stall_cycles, perf_starve_cycles;
`endif

  symbol_streamer_if #(.WORD_W(WORD_W)) in_if ();

  symbol_streamer #(.WORD_W(WORD_W), .LEN_W(LEN_W), .DRAIN_CYCLES(DRAIN)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .num_symbols (num_symbols),
    .in_if       (in_if),
    .hold        (hold),
    .sym_out     (sym_out),
    .sym_run     (sym_run),
    .auto_reset  (auto_reset),
    .sym_offset  (sym_offset),
    .busy        (busy),
`ifdef SYMBOL_STREAMER_PERF_EN
    .done        (done),
    .perf_stall_cycles  (perf_stall_cycles),
    .perf_starve_cycles (perf_starve_cycles)
`else
    .done        (done)
`endif
  );

  int checks = 0;
  int errors = 0;

  logic [63:0] words[$];
  int   n_job, rx, accepted, word_idx, cyc, last_run_cyc, first_acc_cyc, start_cyc, done_cyc;
  int   valid_pct, hold_pct, hold_trigger, hold_left, reset_at, glitch_at;
  bit   dense, aborted, start_pending, done_seen, hold_fired, reset_fired, glitch_fired;
  logic acc_pre, hold_pre, reset_pre, start_pre;
  logic [7:0]       prev_sym;
  logic [LEN_W-1:0] prev_off;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, actual, expected);
    end
  endtask

  function automatic logic [7:0] expSym(input int i);
    logic [63:0] w;
    w = words[i / BYTES];
    return w[(i % BYTES) * 8 +: 8];
  endfunction

  task automatic loadWords(input int n);
    words.delete();
    for (int i = 0; i < (n + BYTES - 1) / BYTES + 1; i++) words.push_back({$urandom, $urandom});
  endtask

  task automatic sampleOutputs();
    if (!reset_pre) begin
      checkOutput("rst_sym_out", sym_out, 0);
      checkOutput("rst_sym_run", sym_run, 0);
      checkOutput("rst_auto_reset", auto_reset, 1);
      checkOutput("rst_offset", sym_offset, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_in_ready", in_if.in_ready, 0);
      aborted = 1'b1;
    end else begin
      if (start_pre && start_cyc < 0) begin
        start_cyc = cyc;
        checkOutput("flush_auto_reset", auto_reset, 1);
        checkOutput("flush_busy", busy, 1);
        checkOutput("flush_offset", sym_offset, 0);
      end
      if (dense && rx > 0 && rx < n_job) checkOutput("no_bubble", sym_run, !hold_pre);
      if (hold_pre) checkOutput("hold_blocks", sym_run, 0);
      if (sym_run) begin
        if (rx < n_job) begin
          checkOutput("sym_out", sym_out, expSym(rx));
          checkOutput("sym_offset", sym_offset, rx);
        end else begin
          checkOutput("extra_run", sym_run, 0);
        end
        if (rx == 0 && dense) checkOutput("first_latency", cyc, first_acc_cyc + 1);
        rx++;
        last_run_cyc = cyc;
      end else if (!auto_reset) begin
        checkOutput("freeze_sym", sym_out, prev_sym);
        checkOutput("freeze_off", sym_offset, prev_off);
      end
      if (done) begin
        checkOutput("done_count", rx, n_job);
        checkOutput("done_words", accepted, (n_job + BYTES - 1) / BYTES);
        checkOutput("done_busy", busy, 1);
        if (n_job > 0) checkOutput("done_delay", cyc - last_run_cyc, DRAIN + 1);
        else           checkOutput("empty_delay", cyc - start_cyc, DRAIN + 1);
        done_seen = 1'b1;
        done_cyc  = cyc;
      end else if (done_seen && cyc == done_cyc + 1) begin
        checkOutput("idle_busy", busy, 0);
        checkOutput("idle_auto_reset", auto_reset, 1);
      end
    end
    prev_sym = sym_out;
    prev_off = sym_offset;
  endtask

  task automatic applyStimulus();
    @(negedge clk);
    start       = 1'b0;
    num_symbols = $urandom;
    if (start_pending) begin
      start         = 1'b1;
      num_symbols   = n_job;
      start_pending = 1'b0;
    end else if (glitch_at >= 0 && !glitch_fired && rx == glitch_at) begin
      start        = 1'b1;
      num_symbols  = 3;
      glitch_fired = 1'b1;
    end
    if (reset_at >= 0 && !reset_fired && rx == reset_at) begin
      reset       = 1'b0;
      reset_fired = 1'b1;
    end else begin
      reset = 1'b1;
    end
    if (hold_trigger >= 0 && !hold_fired && rx == hold_trigger) begin
      hold_left  = 4;
      hold_fired = 1'b1;
    end
    if (hold_left > 0) begin
      hold = 1'b1;
      hold_left--;
    end else if (dense) hold = 1'b0;
    else hold = ($urandom_range(99) < hold_pct);
    in_if.in_valid = (word_idx < words.size()) && (dense || $urandom_range(99) < valid_pct);
    if (in_if.in_valid) in_if.in_data = words[word_idx];
    else                in_if.in_data = {$urandom, $urandom};
    #4;
    start_pre = start;
    reset_pre = reset;
    hold_pre  = hold;
    acc_pre   = in_if.in_valid && in_if.in_ready;
    if (!busy || auto_reset || rx >= n_job) checkOutput("in_ready_quiet", in_if.in_ready, 0);
    if (acc_pre) begin
      accepted++;
      word_idx++;
      if (first_acc_cyc < 0) first_acc_cyc = cyc + 1;
    end
    @(posedge clk);
    #1;
    cyc++;
    sampleOutputs();
  endtask

  task automatic runJob(input int n, input bit d, input int vp, input int hp,
                        input int ht, input int ra, input int ga);
    int budget;
    n_job = n; dense = d; valid_pct = vp; hold_pct = hp;
    hold_trigger = ht; reset_at = ra; glitch_at = ga;
    rx = 0; accepted = 0; word_idx = 0; hold_left = 0;
    first_acc_cyc = -1; start_cyc = -1; last_run_cyc = -1; done_cyc = -1;
    aborted = 1'b0; done_seen = 1'b0; hold_fired = 1'b0; reset_fired = 1'b0; glitch_fired = 1'b0;
    start_pending = 1'b1;
    budget = 30 * n + 60;
    for (int c = 0; c < budget; c++) begin
      applyStimulus();
      if (aborted || (done_seen && cyc > done_cyc)) break;
    end
    checkOutput("job_finished", aborted || (done_seen && cyc > done_cyc), 1);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; hold = 1'b0; num_symbols = '0;
    in_if.in_valid = 1'b0; in_if.in_data = '0;
    cyc = 0; rx = 0; n_job = 0; prev_sym = '0; prev_off = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("init_sym_out", sym_out, 0);
    checkOutput("init_sym_run", sym_run, 0);
    checkOutput("init_auto_reset", auto_reset, 1);
    checkOutput("init_offset", sym_offset, 0);
    checkOutput("init_busy", busy, 0);
    checkOutput("init_done", done, 0);
    checkOutput("init_in_ready", in_if.in_ready, 0);

    // Short job inside a single word: trailing bytes must be dropped.
    words.delete();
    words.push_back(64'h0706050403020100);
    words.push_back(64'hFFEEDDCCBBAA9988);
    runJob(5, 1'b1, 100, 0, -1, -1, -1);

    loadWords(24);
    runJob(24, 1'b1, 100, 0, -1, -1, -1);

    loadWords(20);
    runJob(20, 1'b1, 100, 0, 5, -1, -1);
`ifdef SYMBOL_STREAMER_PERF_EN
    checkOutput("perf_stall", perf_stall_cycles, 4);
`endif

    words.delete();
    words.push_back({$urandom, $urandom});
    runJob(0, 1'b1, 100, 0, -1, -1, -1);

    loadWords(40);
    runJob(40, 1'b1, 100, 0, -1, 10, -1);
    runJob(40, 1'b1, 100, 0, -1, -1, -1);

    loadWords(20);
    runJob(20, 1'b1, 100, 0, -1, -1, 7);

    for (int j = 0; j < 8; j++) begin
      int n;
      n = (j == 0) ? 8 : (j == 1) ? 1 : $urandom_range(2, 40);
      loadWords(n);
      runJob(n, 1'b0, 60, 25, -1, -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
